// File: rtl/light_saber_blade_config_pkg.sv
// light_saber_blade_config_pkg
// Shared definitions for the lightsaber blade settings register bank.
// Holds the default field widths and the blade-configuration code constants.
// The codes are only named here. The register bank stores any code verbatim.
package light_saber_blade_config_pkg;

  // Default field widths
  localparam int COLOR_W_DEF = 8;
  localparam int INT_W_DEF   = 2;
  localparam int DEC_W_DEF   = 6;
  localparam int CFG_W_DEF   = 2;

  // Blade configuration codes
  localparam logic [1:0] CFG_SINGLE     = 2'd0;
  localparam logic [1:0] CFG_CROSSGUARD = 2'd1;
  localparam logic [1:0] CFG_DOUBLE     = 2'd2;
  localparam logic [1:0] CFG_SPLIT      = 2'd3;

endpackage

// File: rtl/light_saber_blade_config_settings_reg.sv
// settings_reg
// Parameterised-width register with synchronous reset and load enable.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears the register
//   load - when high, captures d on the next rising edge
//   d    - data in (W bits)
//   q    - registered data out (W bits), driven straight from the flop
module settings_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end
  end

  // Reset takes priority over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/light_saber_blade_config.sv
// light_saber_blade_config
// Settings register bank for the lightsaber. It captures the blade color,
// length and configuration while the saber is on, and holds them while the
// saber is off.
// Ports:
//   clk, rst                    - clock and synchronous active-high reset
//   on                          - registered saber-on state, used as load enable
//   r_in, g_in, b_in            - requested color channels (COLOR_W each)
//   len_int_in, len_dec_in      - requested length, integer and hundredths parts
//   cfg_in                      - requested blade configuration code
//   r_out, g_out, b_out         - held color channels
//   len_int_out, len_dec_out    - held length
//   cfg_out                     - held blade configuration
module light_saber_blade_config
  import light_saber_blade_config_pkg::*;
#(
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int INT_W   = INT_W_DEF,
  parameter int DEC_W   = DEC_W_DEF,
  parameter int CFG_W   = CFG_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               on,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  input  logic [INT_W-1:0]   len_int_in,
  input  logic [DEC_W-1:0]   len_dec_in,
  input  logic [CFG_W-1:0]   cfg_in,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out,
  output logic [INT_W-1:0]   len_int_out,
  output logic [DEC_W-1:0]   len_dec_out,
  output logic [CFG_W-1:0]   cfg_out
);

  // All groups share the same load enable, so every field updates in the same
  // cycle and the bank never shows a partial update.
  settings_reg #(.W(3*COLOR_W)) u_color_reg (
    .clk  (clk),
    .rst  (rst),
    .load (on),
    .d    ({r_in, g_in, b_in}),
    .q    ({r_out, g_out, b_out})
  );

  // The decimal part is kept as-is. There is no carry into the integer part.
  settings_reg #(.W(INT_W + DEC_W)) u_length_reg (
    .clk  (clk),
    .rst  (rst),
    .load (on),
    .d    ({len_int_in, len_dec_in}),
    .q    ({len_int_out, len_dec_out})
  );

  settings_reg #(.W(CFG_W)) u_cfg_reg (
    .clk  (clk),
    .rst  (rst),
    .load (on),
    .d    (cfg_in),
    .q    (cfg_out)
  );

endmodule

// File: tb/tb_light_saber_blade_config.sv
// tb_light_saber_blade_config
// Self-checking bench for the lightsaber blade settings register bank.
// Each test task drives one cycle at a time and pushes the expected output
// word to a scoreboard queue. After the edge, the task pops the entry and
// compares it inline against the DUT outputs.
module tb_light_saber_blade_config;
  import light_saber_blade_config_pkg::*;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] li;
    logic [5:0] ld;
    logic [1:0] cfg;
  } settings_t;

  logic       clk;
  logic       rst;
  logic       on;
  logic [7:0] r_in, g_in, b_in;
  logic [1:0] len_int_in;
  logic [5:0] len_dec_in;
  logic [1:0] cfg_in;
  logic [7:0] r_out, g_out, b_out;
  logic [1:0] len_int_out;
  logic [5:0] len_dec_out;
  logic [1:0] cfg_out;

  settings_t exp_q[$];
  settings_t expv;
  settings_t obs;
  int vectors     = 0;
  int miscompares = 0;

  light_saber_blade_config dut (
    .clk         (clk),
    .rst         (rst),
    .on          (on),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .len_int_in  (len_int_in),
    .len_dec_in  (len_dec_in),
    .cfg_in      (cfg_in),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .len_int_out (len_int_out),
    .len_dec_out (len_dec_out),
    .cfg_out     (cfg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stop the run if the sequence ever fails to finish.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one cycle of stimulus at the negedge and waits for the next
  // active edge. It then returns at the following negedge so that outputs
  // are sampled away from the edge.
  task automatic drive(input logic r_s, input logic on_s, input settings_t in_s);
    rst        = r_s;
    on         = on_s;
    r_in       = in_s.r;
    g_in       = in_s.g;
    b_in       = in_s.b;
    len_int_in = in_s.li;
    len_dec_in = in_s.ld;
    cfg_in     = in_s.cfg;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    settings_t junk = '{r:8'hA5, g:8'h5A, b:8'h3C, li:2'd3, ld:6'd41, cfg:CFG_SPLIT};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('0);
      drive(1'b1, 1'b1, junk);
      obs = {r_out, g_out, b_out, len_int_out, len_dec_out, cfg_out};
      expv = exp_q.pop_front();
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL reset[%0d]: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_load();
    settings_t v = '{r:8'd128, g:8'd128, b:8'd128, li:2'd1, ld:6'd50, cfg:CFG_DOUBLE};
    exp_q.push_back(v);
    drive(1'b0, 1'b1, v);
    obs = {r_out, g_out, b_out, len_int_out, len_dec_out, cfg_out};
    expv = exp_q.pop_front();
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL load: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_hold_off();
    settings_t held = '{r:8'd128, g:8'd128, b:8'd128, li:2'd1, ld:6'd50, cfg:CFG_DOUBLE};
    settings_t nv   = '{r:8'd128, g:8'd0,   b:8'd128, li:2'd2, ld:6'd33, cfg:CFG_SPLIT};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(held);
      drive(1'b0, 1'b0, nv);
      obs = {r_out, g_out, b_out, len_int_out, len_dec_out, cfg_out};
      expv = exp_q.pop_front();
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL hold[%0d]: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_resume();
    settings_t nv = '{r:8'd128, g:8'd0, b:8'd128, li:2'd2, ld:6'd33, cfg:CFG_SPLIT};
    exp_q.push_back(nv);
    drive(1'b0, 1'b1, nv);
    obs = {r_out, g_out, b_out, len_int_out, len_dec_out, cfg_out};
    expv = exp_q.pop_front();
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL resume: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_reset_priority();
    settings_t nv = '{r:8'd17, g:8'd34, b:8'd51, li:2'd1, ld:6'd7, cfg:CFG_CROSSGUARD};
    exp_q.push_back('0);
    exp_q.push_back(nv);
    drive(1'b1, 1'b1, nv);
    obs = {r_out, g_out, b_out, len_int_out, len_dec_out, cfg_out};
    expv = exp_q.pop_front();
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL rst_prio: got %h expected %h", obs, expv);
    end
    drive(1'b0, 1'b1, nv);
    obs = {r_out, g_out, b_out, len_int_out, len_dec_out, cfg_out};
    expv = exp_q.pop_front();
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL rst_release: got %h expected %h", obs, expv);
    end
  endtask

  // Reset while off clears the bank. Data presented while still off must not
  // load, and the first edge with on=1 after that must load it.
  task automatic test_reset_mid_off();
    settings_t nv = '{r:8'd9, g:8'd200, b:8'd77, li:2'd2, ld:6'd62, cfg:CFG_SINGLE};
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp_q.push_back(nv);
    drive(1'b1, 1'b0, nv);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) drive(1'b0, 1'b0, nv);
      if (i == 2) drive(1'b0, 1'b1, nv);
      obs = {r_out, g_out, b_out, len_int_out, len_dec_out, cfg_out};
      expv = exp_q.pop_front();
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL rst_mid_off[%0d]: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_extremes();
    settings_t v = '{r:8'd255, g:8'd255, b:8'd255, li:2'd3, ld:6'd63, cfg:CFG_SINGLE};
    exp_q.push_back(v);
    drive(1'b0, 1'b1, v);
    obs = {r_out, g_out, b_out, len_int_out, len_dec_out, cfg_out};
    expv = exp_q.pop_front();
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL extremes: got %h expected %h", obs, expv);
    end
  endtask

  // Consecutive loads with distinct words. This also checks that each field
  // maps to its own output.
  task automatic test_back_to_back();
    settings_t v[4];
    v[0] = '{r:8'h01, g:8'h02, b:8'h04, li:2'd0, ld:6'd1,  cfg:CFG_CROSSGUARD};
    v[1] = '{r:8'h80, g:8'h40, b:8'h20, li:2'd1, ld:6'd32, cfg:CFG_DOUBLE};
    v[2] = '{r:8'h00, g:8'hFF, b:8'h00, li:2'd2, ld:6'd0,  cfg:CFG_SPLIT};
    v[3] = '{r:8'h5C, g:8'h00, b:8'hE3, li:2'd3, ld:6'd21, cfg:CFG_SINGLE};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(v[i]);
      drive(1'b0, 1'b1, v[i]);
      obs = {r_out, g_out, b_out, len_int_out, len_dec_out, cfg_out};
      expv = exp_q.pop_front();
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("[TB] FAIL b2b[%0d]: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    on  = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    len_int_in = '0; len_dec_in = '0; cfg_in = '0;
    @(negedge clk);
    test_reset();
    test_load();
    test_hold_off();
    test_resume();
    test_reset_priority();
    test_reset_mid_off();
    test_extremes();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
